data_mem_ctrl: RTL
==================

# data_mem_ctrl

Parametrised single-port data memory with a request interface, per-lane write enables, out-of-range address detection and a post-reset clear sequence. Successor to the fixed 16x24 data memory. It serves as the processor-side data store: width, depth and lane granularity are set per instance. After every reset the block writes a known value to all entries before it accepts requests, so it needs no simulation-only initial contents.

## Interface
- DATA_W, 24, word width in bits; must be a multiple of LANE_W
- ADDR_W, 5, address width in bits
- DEPTH, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W
- LANE_W, 8, write-lane granularity in bits; NLANES = DATA_W/LANE_W
- CLEAR_VAL, 0 (DATA_W bits), value written to every entry during clear

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- req  in  1  request strobe, sampled on the clk edge
- we  in  1  1 = write, 0 = read (qualified by req)
- be  in  NLANES  per-lane write enable; lane i = bits [i*LANE_W +: LANE_W]
- addr  in  ADDR_W  word address
- data_in  in  DATA_W  write data
- ready  out  1  block accepts a request this cycle
- busy  out  1  clear sequence in progress
- rd_valid  out  1  one-cycle pulse; data_out holds read result
- data_out  out  DATA_W  registered read data
- err  out  1  one-cycle pulse; the accepted request had addr ≥ DEPTH

## Operation
- A request is accepted when req && ready. A request made with ready=0 is dropped, not queued.
- The state machine has two states, CLEAR and IDLE.
  - rst=1: state → CLEAR, clear_ptr → 0, all outputs → reset values.
  - CLEAR: each cycle writes CLEAR_VAL to mem[clear_ptr] and increments clear_ptr. When clear_ptr = DEPTH-1, that write completes the clear and the next state is IDLE. ready=0 and busy=1 throughout CLEAR.
  - IDLE: ready=1 and busy=0. The block stays in IDLE until rst.
- Write (accepted, we=1, addr < DEPTH): for each lane i with be[i]=1, mem[addr] lane i ← data_in lane i. Other lanes are unchanged. A write produces no rd_valid. A write with be=0 is a legal no-op.
- Read (accepted, we=0, addr < DEPTH): data_out ← mem[addr] and rd_valid=1 on the next cycle. be is ignored.
- Out of range (accepted, addr ≥ DEPTH):
  - A write is suppressed; there is no aliasing or truncation onto a lower address.
  - A read returns data_out=0 with rd_valid=1.
  - err=1 on the next cycle in both cases.
- data_out holds its last value while rd_valid=0. err and rd_valid are never held beyond one cycle per request.
- Back-to-back requests are allowed on every cycle in IDLE. A read of an address written in the previous cycle returns the new data.
- rst at any time, including mid-CLEAR, mid-request, or while rd_valid is pending, aborts all activity.
  - Any in-flight rd_valid/err is cancelled.
  - CLEAR restarts from address 0.
  - Memory contents at the time of rst are irrelevant, because all entries are rewritten.

## Timing
- Reset values: ready=0, busy=1, rd_valid=0, err=0, data_out=0.
- Clear duration is exactly DEPTH cycles after the cycle rst is deasserted. ready rises on cycle DEPTH+1 after deassertion (cycle 1 = first cycle with rst=0).
- Read latency is 1 cycle: request accepted at edge N gives rd_valid/data_out/err valid after edge N+1.
- Write takes effect at the accepting edge and is visible to a read accepted at edge N+1.
- Throughput is one request per cycle in IDLE. There are no wait states.
- The memory array has no reset; only the control path and output registers are reset.

## Test plan
- Reset/clear: rst high 2 cycles then low → ready=0, busy=1 for exactly 16 cycles, then ready=1. Reading addr 0..15 returns 0x000000 on each, with rd_valid one cycle after each request.
- Full write/read: write addr 3, be=3'b111, data 0x654321, then read addr 3 on the next cycle → rd_valid=1 with data_out=0x654321, err=0.
- Lane merge: write addr 5 with 0x123456 and be=3'b111. Then write addr 5 with 0xAABBCC and be=3'b010. Then write addr 5 with 0xFFFFFF and be=3'b000. Read addr 5 → 0x12BB56.
- Out of range:
  - Write addr 16 with 0x999999 → err pulse, no rd_valid. Read addr 0 → unchanged.
  - Read addr 31 → rd_valid=1, err=1, data_out=0.
- Busy drop and mid-clear reset: assert req with write to addr 2 during CLEAR → dropped, and addr 2 reads 0. Write 0x070000 to addr 2 in IDLE, then pulse rst when the read of addr 2 is accepted → no rd_valid. The full 16-cycle clear restarts, and addr 2 reads 0.
- Parameter sweep: DATA_W=32, LANE_W=8, DEPTH=10, ADDR_W=4 → 10-cycle clear. be=4'b1001 writes bytes 3 and 0 only. Addr 10..15 raise err.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for data_mem_ctrl: request fields from the processor side,
// status and read-response fields from the memory side.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5,
  parameter int LANE_W = 8
);
  localparam int NLANES = DATA_W / LANE_W;

  logic              req;
  logic              we;
  logic [NLANES-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              busy;
  logic              rd_valid;
  logic [DATA_W-1:0] data_out;
  logic              err;

  modport master (
    output req, we, be, addr, data_in,
    input  ready, busy, rd_valid, data_out, err
  );

  modport slave (
    input  req, we, be, addr, data_in,
    output ready, busy, rd_valid, data_out, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with lane write enables, out-of-range detection and a
// post-reset sweep that writes CLEAR_VAL to every entry before requests are accepted.
module data_mem_ctrl #(
  parameter int                DATA_W    = 24,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 16,
  parameter int                LANE_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_ctrl_if.slave bus
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  clear_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept_p0;
  logic              in_range_p0;
  logic              wr_en_p0;
  logic              rd_en_p0;
  logic [IDX_W-1:0]  idx_p0;

  logic              rd_valid_p1;
  logic              err_p1;
  logic [DATA_W-1:0] data_out_p1;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NLANES-1:0] lane_en
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_en[i]) begin
        merged[i*LANE_W +: LANE_W] = new_word[i*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clear_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR && clear_ptr != LAST_IDX) begin
        clear_ptr <= clear_ptr + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    bus.ready = 1'b0;
    bus.busy  = 1'b1;
    case (state)
      CLEAR: begin
        if (clear_ptr == LAST_IDX) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        bus.ready = 1'b1;
        bus.busy  = 1'b0;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // p0: request decode; addresses at or beyond DEPTH never reach the array
  always_comb begin
    accept_p0   = bus.req && (state == IDLE);
    in_range_p0 = ({1'b0, bus.addr} < DEPTH_A);
    idx_p0      = bus.addr[IDX_W-1:0];
    wr_en_p0    = accept_p0 && bus.we && in_range_p0;
    rd_en_p0    = accept_p0 && !bus.we;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clear_ptr] <= CLEAR_VAL;
      end else if (wr_en_p0) begin
        mem[idx_p0] <= lane_merge(mem[idx_p0], bus.data_in, bus.be);
      end
    end
  end

  // p1: registered response; data_out holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_p1 <= 1'b0;
      err_p1      <= 1'b0;
      data_out_p1 <= '0;
    end else begin
      rd_valid_p1 <= rd_en_p0;
      err_p1      <= accept_p0 && !in_range_p0;
      if (rd_en_p0) begin
        data_out_p1 <= in_range_p0 ? mem[idx_p0] : '0;
      end
    end
  end

  assign bus.rd_valid = rd_valid_p1;
  assign bus.err      = err_p1;
  assign bus.data_out = data_out_p1;

endmodule
